dual_ad_pipe: RTL

- Parametrised successor to the dual A/D pre-adder path of the DSP48E1 slice model.
- Adds a registered INMODE stage (INMODECE behaviour), sign-aware pre-add with an overflow flag, and a valid tag aligned with multiplier-path latency.
- Sits between the A/ACIN/D input ports and the multiplier A operand.
- Feeds acout to the next slice and xmux to the X multiplexer.

---
 rtl/dual_ad_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dual_ad_pipe.sv
// dual_ad_pipe: A/ACIN/D input pipeline with INMODE register, signed pre-adder
// with overflow flag, and a valid tag that tracks the data through the same
// clock enables. Optional build macro DUAL_AD_PIPE_SAT_EN saturates the
// pre-adder result on overflow instead of wrapping.
module dual_ad_pipe #(
    parameter int    A_WIDTH    = 30,
    parameter int    D_WIDTH    = 25,
    parameter string A_INPUT    = "DIRECT",
    parameter int    A_REG      = 1,
    parameter int    A_CASC_REG = 1,   // must be <= A_REG, and nonzero when A_REG != 0
    parameter int    D_REG      = 1,
    parameter int    AD_REG     = 1,
    parameter int    INMODE_REG = 1,
    parameter string USE_DPORT  = "FALSE"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cea1,
    input  logic               cea2,
    input  logic               ced,
    input  logic               cead,
    input  logic               ceinmode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [A_WIDTH-1:0] acin,
    input  logic [D_WIDTH-1:0] d,
    input  logic [3:0]         inmode,
    input  logic               in_valid,
    output logic [A_WIDTH-1:0] acout,
    output logic [A_WIDTH-1:0] xmux,
    output logic [D_WIDTH-1:0] amult,
    output logic               ad_ovf,
    output logic               out_valid
);
    localparam bit CASC_IN = (A_INPUT == "CASCADE");
    localparam bit USE_AD  = (USE_DPORT == "TRUE");

    logic [A_WIDTH-1:0] a_sel, a1_q, a2_q, a2_d, a_fin, a_op;
    logic [D_WIDTH-1:0] d_q, d_mux;
    logic [3:0]         im_q, im;
    logic [D_WIDTH:0]   aop, dop, sum;
    logic [D_WIDTH-1:0] ad_d, ad_q, ad_mux;
    logic               ovf_d, ovf_q, ovf_mux;
    logic               va1_q, va2_q, va2_d, vad_q, va_fin;

    assign a_sel = CASC_IN ? acin : a;
    // With two A stages A2 is fed from A1; otherwise A2 samples the input directly.
    assign a2_d  = (A_REG == 2) ? a1_q : a_sel;
    assign a_fin = (A_REG == 0) ? a_sel : a2_q;
    assign xmux  = a_fin;
    assign acout = (A_CASC_REG == 1 && A_REG == 2) ? a1_q : a_fin;

    // A1/A2 data registers, each with its own enable
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q <= '0;
            a2_q <= '0;
        end else begin
            if (cea1) a1_q <= a_sel;
            if (cea2) a2_q <= a2_d;
        end
    end

    // D and INMODE input registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            im_q <= '0;
        end else begin
            if (ced)      d_q  <= d;
            if (ceinmode) im_q <= inmode;
        end
    end

    assign d_mux = (D_REG == 1) ? d_q : d;
    assign im    = (INMODE_REG == 1) ? im_q : inmode;
    // im[0] can only pick A1 when A1 actually exists.
    assign a_op  = (im[0] && A_REG == 2) ? a1_q : a_fin;

    // Upper A bits only travel to xmux/acout, never into the pre-adder.
    if (A_WIDTH > D_WIDTH) begin : g_unused
        logic unused_a_hi;
        assign unused_a_hi = ^a_op[A_WIDTH-1:D_WIDTH];
    end

    // Signed pre-add one bit wider than D so overflow is visible in the top two bits
    always_comb begin
        aop   = im[1] ? '0 : {a_op[D_WIDTH-1], a_op[D_WIDTH-1:0]};
        dop   = im[2] ? {d_mux[D_WIDTH-1], d_mux} : '0;
        sum   = im[3] ? (dop - aop) : (dop + aop);
        ovf_d = sum[D_WIDTH] ^ sum[D_WIDTH-1];
        ad_d  = sum[D_WIDTH-1:0];
`ifdef DUAL_AD_PIPE_SAT_EN
        // sum[D_WIDTH] is the true sign of the unwrapped result.
        if (ovf_d)
            ad_d = sum[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}}
                                : {1'b0, {(D_WIDTH-1){1'b1}}};
`endif
    end

    // AD register keeps result and overflow flag together
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_q  <= '0;
            ovf_q <= 1'b0;
        end else if (cead) begin
            ad_q  <= ad_d;
            ovf_q <= ovf_d;
        end
    end

    assign ad_mux  = (AD_REG == 1) ? ad_q : ad_d;
    assign ovf_mux = (AD_REG == 1) ? ovf_q : ovf_d;
    assign amult   = USE_AD ? ad_mux : aop[D_WIDTH-1:0];
    assign ad_ovf  = USE_AD ? ovf_mux : 1'b0;

    assign va2_d  = (A_REG == 2) ? va1_q : in_valid;
    assign va_fin = (A_REG == 0) ? in_valid : va2_q;

    // Valid shadow stages share the enables of the data they follow
    always_ff @(posedge clk) begin
        if (rst) begin
            va1_q <= 1'b0;
            va2_q <= 1'b0;
            vad_q <= 1'b0;
        end else begin
            if (cea1) va1_q <= in_valid;
            if (cea2) va2_q <= va2_d;
            if (cead) vad_q <= va_fin;
        end
    end

    assign out_valid = (USE_AD && AD_REG == 1) ? vad_q : va_fin;
endmodule
